// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the I/D memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int MEM_LAT_DEFAULT      = 4;
    localparam int MAX_D_STREAK_DEFAULT = 2;
endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select with D-streak fairness counter
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   take,
    output owner_t win
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] d_streak;

    // D is preferred unless I has been passed over MAX_D_STREAK times in a row
    always_comb begin
        win = OWN_I;
        if (d_req && !(i_req && d_streak == STREAK_MAX)) begin
            win = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_streak <= '0;
        end else if (take) begin
            if (win == OWN_D && i_req) begin
                if (d_streak != STREAK_MAX) begin
                    d_streak <= d_streak + SW'(1);
                end
            end else begin
                d_streak <= '0;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding I/D arbiter for a fixed-latency memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT      = MEM_LAT_DEFAULT,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [15:0] i_rdata,
    output logic        i_gnt,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        d_gnt,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);
    localparam int CW = $clog2(MEM_LAT + 1);

    state_t        state;
    owner_t        owner;
    owner_t        win;
    logic [CW-1:0] cnt;
    logic          take;

    assign take = (state == IDLE) && (i_req || d_req);

    mem_arb_pick #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_pick (
        .clk  (clk),
        .rst_n(rst_n),
        .i_req(i_req),
        .d_req(d_req),
        .take (take),
        .win  (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_I;
            cnt       <= '0;
            busy      <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= 1'b0;
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        state  <= BUSY;
                        busy   <= 1'b1;
                        owner  <= win;
                        mem_en <= 1'b1;
                        cnt    <= CW'(MEM_LAT);
                        if (win == OWN_D) begin
                            d_gnt     <= 1'b1;
                            mem_wr    <= d_wr;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            i_gnt     <= 1'b1;
                            mem_wr    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    // cnt reaches 0 exactly in the cycle mem_rdata is valid
                    if (cnt == '0) begin
                        state <= DONE;
                        if (owner == OWN_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!mem_wr) begin
                                d_rdata <= mem_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    i_gnt <= 1'b0;
                    d_gnt <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int LAT  = 4;
    localparam int MAXS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, i_req, i_ack, i_gnt, d_req, d_wr, d_ack, d_gnt;
    logic        mem_en, mem_wr, busy;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        l1_i_req, l1_i_ack, l1_i_gnt, l1_d_ack, l1_d_gnt, l1_mem_en, l1_mem_wr, l1_busy;
    logic [15:0] l1_i_addr, l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    mem_arbiter #(.MEM_LAT(LAT), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_gnt(i_gnt),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_gnt(d_gnt),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(1), .MAX_D_STREAK(MAXS)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata), .i_gnt(l1_i_gnt),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_ack(l1_d_ack), .d_rdata(l1_d_rdata), .d_gnt(l1_d_gnt),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {int cyc; logic [15:0] ir; logic [15:0] dr;} ack_t;
    typedef struct {int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata;} men_t;
    ack_t iq[$];
    ack_t dq[$];
    men_t mq[$];
    int   log_cyc[$];
    logic log_side[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hC3C3);
    endfunction

    // Memory: read data is valid only in the single cycle LAT after the strobe
    logic [15:0] mem_arr [0:1023];
    logic        mem_set [0:1023];
    logic [15:0] pend_data;
    int          pend_cnt;
    initial begin
        for (int k = 0; k < 1024; k++) mem_set[k] = 1'b0;
        pend_cnt  = 0;
        pend_data = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                pend_data = mem_set[mem_addr[9:0]] ? mem_arr[mem_addr[9:0]] : init_val(mem_addr);
                if (mem_wr) begin
                    mem_arr[mem_addr[9:0]] = mem_wdata;
                    mem_set[mem_addr[9:0]] = 1'b1;
                end
                pend_cnt = LAT;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
        end
    end
    initial begin
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rdata = (pend_cnt == 1) ? pend_data : 16'($urandom);
        end
    end

    logic l1_pend;
    initial begin
        l1_pend = 1'b0;
        forever begin
            @(posedge clk);
            l1_pend = l1_mem_en;
        end
    end
    initial begin
        l1_mem_rdata = '0;
        forever begin
            @(negedge clk);
            l1_mem_rdata = l1_pend ? (l1_mem_addr ^ 16'h5A5A) : 16'($urandom);
        end
    end

    // Transaction-level reference: when free, pick a winner and predict strobe/ack
    logic [15:0] ref_mem [0:1023];
    logic        ref_set [0:1023];
    initial begin
        int          m_free;
        int          m_streak;
        logic [15:0] m_ir, m_dr, a, cur;
        logic        d_wins;
        men_t        me;
        ack_t        ae;
        for (int k = 0; k < 1024; k++) ref_set[k] = 1'b0;
        m_free = 0; m_streak = 0; m_ir = '0; m_dr = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                iq.delete(); dq.delete(); mq.delete();
                m_streak = 0; m_ir = '0; m_dr = '0;
                m_free = cyc + 1;
            end else if (cyc >= m_free && (i_req || d_req)) begin
                d_wins = d_req && !(i_req && m_streak == MAXS);
                if (d_wins && i_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                else m_streak = 0;
                a   = d_wins ? d_addr : i_addr;
                cur = ref_set[a[9:0]] ? ref_mem[a[9:0]] : init_val(a);
                me.cyc = cyc + 1; me.wr = d_wins && d_wr; me.addr = a; me.wdata = d_wdata;
                mq.push_back(me);
                if (d_wins) begin
                    if (d_wr) begin
                        ref_mem[a[9:0]] = d_wdata;
                        ref_set[a[9:0]] = 1'b1;
                    end else begin
                        m_dr = cur;
                    end
                end else begin
                    m_ir = cur;
                end
                ae.cyc = cyc + 2 + LAT; ae.ir = m_ir; ae.dr = m_dr;
                if (d_wins) dq.push_back(ae);
                else iq.push_back(ae);
                m_free = cyc + 3 + LAT;
            end
            cyc++;
        end
    end

    initial begin
        men_t me;
        ack_t ae;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (mq.size() == 0) chk("mem_en_spurious", 64'd1, 64'd0);
                else begin
                    me = mq.pop_front();
                    chk("mem_strobe", {cyc[15:0], 15'd0, mem_wr, mem_addr, me.wr ? mem_wdata : 16'h0},
                        {me.cyc[15:0], 15'd0, me.wr, me.addr, me.wr ? me.wdata : 16'h0});
                end
            end
            if (i_ack) begin
                log_cyc.push_back(cyc); log_side.push_back(1'b0);
                if (iq.size() == 0) chk("i_ack_spurious", 64'd1, 64'd0);
                else begin
                    ae = iq.pop_front();
                    chk("i_ack", {cyc, i_rdata, d_rdata}, {ae.cyc, ae.ir, ae.dr});
                end
            end
            if (d_ack) begin
                log_cyc.push_back(cyc); log_side.push_back(1'b1);
                if (dq.size() == 0) chk("d_ack_spurious", 64'd1, 64'd0);
                else begin
                    ae = dq.pop_front();
                    chk("d_ack", {cyc, i_rdata, d_rdata}, {ae.cyc, ae.ir, ae.dr});
                end
            end
        end
    end

    task automatic wait_ack(input logic side);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (side ? d_ack : i_ack) break;
        end
        if (k == 200) chk(side ? "d_ack_timeout" : "i_ack_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic i_txn(input logic [15:0] a);
        i_addr = a; i_req = 1'b1;
        wait_ack(1'b0);
        i_req = 1'b0;
    endtask

    task automatic d_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        d_wr = wr; d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_ack(1'b1);
        d_req = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctrl"}, {57'd0, i_ack, i_gnt, d_ack, d_gnt, mem_en, mem_wr, busy}, 64'd0);
        chk({name, "_data"}, {i_rdata, d_rdata, mem_addr, mem_wdata}, 64'd0);
    endtask

    initial begin
        logic exp_side [6];
        int   a1, a2;
        exp_side = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        l1_i_req = 1'b0; l1_i_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        i_txn(16'h0010);
        chk("i_rdata_beef", 64'(i_rdata), 64'(16'hBEEF));
        d_txn(1'b1, 16'h0200, 16'h1234);
        d_txn(1'b0, 16'h0200, 16'h0000);
        chk("d_rdata_raw", 64'(d_rdata), 64'(16'h1234));

        // Both sides requesting continuously: fairness order and ack spacing
        log_cyc.delete(); log_side.delete();
        fork
            for (int n = 0; n < 2; n++) i_txn(16'h0020 + 16'(n));
            for (int n = 0; n < 4; n++) d_txn(1'b0, 16'h0030 + 16'(n), 16'h0);
        join
        for (int k = 0; k < 6; k++) begin
            if (k < log_side.size()) chk($sformatf("grant_order_%0d", k), 64'(log_side[k]), 64'(exp_side[k]));
            else chk($sformatf("grant_order_%0d", k), 64'd0, 64'd1);
            if (k > 0 && k < log_cyc.size())
                chk($sformatf("ack_spacing_%0d", k), 64'(log_cyc[k] - log_cyc[k-1]), 64'(LAT + 3));
        end

        // D request arriving while I is in flight
        log_cyc.delete(); log_side.delete();
        fork
            i_txn(16'h0004);
            begin repeat (2) @(posedge clk); #1; d_txn(1'b0, 16'h0005, 16'h0); end
        join
        chk("late_d_order", {63'd0, log_side.size() == 2 ? log_side[1] : 1'b0}, 64'd1);
        chk("late_d_spacing", 64'(log_cyc.size() == 2 ? log_cyc[1] - log_cyc[0] : 0), 64'(LAT + 3));

        fork
            for (int n = 0; n < 25; n++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                i_txn(16'($urandom_range(0, 15)));
            end
            for (int m = 0; m < 25; m++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                d_txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
            end
        join

        // Reset in the third BUSY cycle of a D read
        @(posedge clk); #1;
        d_wr = 1'b0; d_addr = 16'h0003; d_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        repeat (12) @(posedge clk); #1;
        i_txn(16'h0007);

        // MEM_LAT=1 build: ack at t+3, back-to-back period 4
        l1_i_addr = 16'h0042; l1_i_req = 1'b1;
        a1 = -1; a2 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (l1_i_ack) begin
                if (a1 < 0) a1 = k;
                else if (a2 < 0) a2 = k;
            end
        end
        @(posedge clk); #1;
        l1_i_req = 1'b0;
        chk("lat1_first_ack", 64'(a1), 64'd3);
        chk("lat1_period", 64'(a2 - a1), 64'd4);
        chk("lat1_rdata", 64'(l1_i_rdata), 64'(16'h0042 ^ 16'h5A5A));

        repeat (10) @(posedge clk);
        chk("queues_drained", 64'(iq.size() + dq.size() + mq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported, fixed-latency main memory between the instruction-fetch side (I) and the data-access side (D) of the CPU. It accepts one outstanding access at a time, drives the memory port, captures read data, and returns a one-cycle acknowledge to the winning requester. It sits between the core's fetch/load-store logic (or their cache miss paths) and the unified memory model. Requesters stall on `req && !ack`.

## Interface
- `MEM_LAT`, 4: cycles from the `mem_en` cycle to the cycle `mem_rdata` is valid (≥1).
- `MAX_D_STREAK`, 2: consecutive D grants allowed while I is waiting before I is forced.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  1  I-side request; held with stable `i_addr` until `i_ack`.
- `i_addr`  in  16  I-side word address (read only).
- `i_ack`  out  1  one-cycle pulse: `i_rdata` valid.
- `i_rdata`  out  16  registered read data for I.
- `i_gnt`  out  1  I owns the memory (BUSY and DONE of its transaction).
- `d_req`  in  1  D-side request; held with stable `d_wr`/`d_addr`/`d_wdata` until `d_ack`.
- `d_wr`  in  1  1 = write, 0 = read.
- `d_addr`  in  16  D-side word address.
- `d_wdata`  in  16  D-side write data.
- `d_ack`  out  1  one-cycle pulse: write done or `d_rdata` valid.
- `d_rdata`  out  16  registered read data for D.
- `d_gnt`  out  1  D owns the memory.
- `mem_en`  out  1  one-cycle memory strobe.
- `mem_wr`  out  1  write qualifier, valid with `mem_en`.
- `mem_addr`  out  16  latched address, held for the whole transaction.
- `mem_wdata`  out  16  latched write data, held for the whole transaction.
- `mem_rdata`  in  16  memory read data, valid `MEM_LAT` cycles after `mem_en`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any `req` is asserted, pick a winner, latch owner/addr/wr/wdata, go to BUSY.
  - Otherwise stay in IDLE.
- Pick rule:
  - Only one requester → it wins.
  - Both requesters → D wins, unless `d_streak == MAX_D_STREAK`, in which case I wins.
- `d_streak` update:
  - Increments on a D grant made while `i_req` is high.
  - Clears on any I grant.
  - Clears on a D grant made while `i_req` is low.
  - Saturates at `MAX_D_STREAK`.
- BUSY:
  - First BUSY cycle: `mem_en` = 1, `mem_wr` = latched wr.
  - Down-counter loads `MEM_LAT` and decrements each cycle.
  - When it reaches 0, capture `mem_rdata` into the owner's rdata register (reads only) and go to DONE.
  - Writes take the same duration as reads.
- DONE:
  - Owner's `ack` = 1 for exactly this cycle.
  - All requests ignored.
  - Next state is IDLE unconditionally.
- `i_rdata`/`d_rdata` hold their value until the next read for that side. The non-owner's rdata never changes.
- Counter width is `$clog2(MEM_LAT+1)`. No address or data arithmetic.

## Timing
- Request sampled in IDLE at cycle t:
  - `gnt` = 1 from t+1.
  - `mem_en` pulses at t+1.
  - `mem_rdata` is sampled at t+1+MEM_LAT.
  - `ack` = 1 at t+2+MEM_LAT (t+6 at default).
  - `gnt` drops at t+3+MEM_LAT.
- A requester may change or deassert `req`/addr from the cycle after `ack`. Re-sampling happens in IDLE at t+3+MEM_LAT, so back-to-back period is MEM_LAT+3.
- A `req` that rises while the FSM is busy waits. No request is lost or reordered within a side.
- `mem_addr`/`mem_wdata`/`mem_wr` are stable from t+1 through DONE. Values outside `mem_en` cycles are don't-care for memory but must not glitch mid-transaction.
- Reset (`rst_n` = 0 at a rising edge), including mid-transaction:
  - State = IDLE, `d_streak` = 0.
  - All outputs 0, including `mem_*` and both rdata registers.
  - An in-flight access is abandoned and never acked.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum (IDLE/BUSY/DONE).
  - Owner encoding `OWN_I` = 0, `OWN_D` = 1.
  - Default `MEM_LAT`.
- One natural sub-module: `mem_arb_pick`, the combinational winner select plus the registered `d_streak` counter.
- FSM, latency counter, and latches live in the top.

## Test plan
- I read only, `i_addr`=0x0010, memory returns 0xBEEF → `mem_en` at t+1, `i_ack` at t+6, `i_rdata`=0xBEEF, `d_ack` never asserts.
- D write 0x1234 to 0x0200, then D read of 0x0200 → write acked at t+6, second grant at t+7, `d_rdata`=0x1234 at t+13.
- `i_req` and `d_req` both held continuously, `MAX_D_STREAK`=2 → grant order D, D, I, D, D, I; each ack is 7 cycles apart.
- Reset pulsed at the third BUSY cycle of a D read → no `d_ack`, all outputs 0 next cycle, and a fresh I request afterwards completes normally in 6 cycles.
- `d_req` rises during an I transaction → D is granted at the cycle after `i_ack`. `i_rdata` is unchanged by the D read.
- `MEM_LAT`=1 build, single read → `ack` at t+3, back-to-back period 4.
